// File: rtl/adc_capture_sequencer_if.sv
// ADC sample input, capture control and capture-buffer write bus for adc_capture_sequencer.
// master drives samples and commands; slave (the sequencer) drives the write port and status.
interface adc_capture_sequencer_if #(
  parameter int nch  = 8,
  parameter int dw   = 16,
  parameter int aw   = 14,
  parameter int decw = 10
);
  logic [nch*dw-1:0] adc_data;
  logic [nch-1:0]    chan_mask;
  logic [1:0]        mode;
  logic [aw-1:0]     pretrig_len;
  logic [decw-1:0]   decim;
  logic              arm;
  logic              trig;
  logic              stop;

  logic [nch*dw-1:0] wdata;
  logic [nch-1:0]    we;
  logic [aw-1:0]     waddr;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [aw-1:0]     trig_addr;
  logic [2:0]        state;

  modport master (
    output adc_data, chan_mask, mode, pretrig_len, decim, arm, trig, stop,
    input  wdata, we, waddr, busy, done, wrapped, trig_addr, state
  );

  modport slave (
    input  adc_data, chan_mask, mode, pretrig_len, decim, arm, trig, stop,
    output wdata, we, waddr, busy, done, wrapped, trig_addr, state
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// Decimated multi-channel ADC capture into a circular buffer (one-shot, pretrigger, continuous).
// Write appears one cycle after its sample strobe; no backpressure, the buffer always accepts.
module adc_capture_sequencer #(
  parameter int nch  = 8,
  parameter int dw   = 16,
  parameter int aw   = 14,
  parameter int decw = 10
) (
  input logic                    clk,
  input logic                    rst,
  adc_capture_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [aw:0] depth = {1'b1, {aw{1'b0}}};

  state_t          st;
  logic [1:0]      mode_q;
  logic [nch-1:0]  mask_q;
  logic [aw:0]     plen_q;
  logic [aw:0]     cnt;
  logic [aw-1:0]   ptr;
  logic [decw-1:0] dcnt;
  logic [decw-1:0] decim_eff;
  logic [1:0]      mode_in;
  logic            busy_st;
  logic            strobe;
  logic            wrap_ok;

  assign mode_in   = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
  assign decim_eff = (bus.decim == '0) ? decw'(1) : bus.decim;
  assign busy_st   = (st == PRE) || (st == ARMED) || (st == POST);
  // arm and stop both kill the sample of the cycle they arrive in
  assign strobe    = busy_st && (dcnt == '0) && !bus.arm && !bus.stop;
  assign wrap_ok   = (st == ARMED) || ((st == POST) && (mode_q == 2'd2));

  assign bus.busy  = busy_st;
  assign bus.state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      mode_q        <= 2'd0;
      mask_q        <= '0;
      plen_q        <= '0;
      cnt           <= '0;
      ptr           <= '0;
      dcnt          <= '0;
      bus.wdata     <= '0;
      bus.we        <= '0;
      bus.waddr     <= '0;
      bus.done      <= 1'b0;
      bus.wrapped   <= 1'b0;
      bus.trig_addr <= '0;
    end else begin
      bus.wdata <= bus.adc_data;
      bus.waddr <= ptr;
      bus.we    <= strobe ? mask_q : '0;
      if (busy_st) begin
        dcnt <= (dcnt == '0) ? decim_eff - decw'(1) : dcnt - decw'(1);
      end
      if (strobe) begin
        ptr <= ptr + aw'(1);
        if ((ptr == '1) && wrap_ok) begin
          bus.wrapped <= 1'b1;
        end
      end

      if (bus.stop && busy_st) begin
        st <= IDLE;
      end else if (bus.arm) begin
        mode_q        <= mode_in;
        mask_q        <= bus.chan_mask;
        plen_q        <= {1'b0, bus.pretrig_len};
        ptr           <= '0;
        bus.waddr     <= '0;
        dcnt          <= '0;
        bus.done      <= 1'b0;
        bus.wrapped   <= 1'b0;
        bus.trig_addr <= '0;
        if (mode_in == 2'd1) begin
          cnt <= {1'b0, bus.pretrig_len};
          st  <= (bus.pretrig_len == '0) ? ARMED : PRE;
        end else begin
          cnt <= depth;
          st  <= POST;
        end
      end else begin
        case (st)
          PRE: begin
            if (strobe) begin
              cnt <= cnt - (aw+1)'(1);
              if (cnt == (aw+1)'(1)) st <= ARMED;
            end
          end
          ARMED: begin
            if (bus.trig) begin
              // a sample taken in the trigger cycle still belongs to the pretrigger window
              bus.trig_addr <= strobe ? ptr + aw'(1) : ptr;
              cnt           <= depth - plen_q;
              st            <= POST;
            end
          end
          POST: begin
            if (strobe && (mode_q != 2'd2)) begin
              cnt <= cnt - (aw+1)'(1);
              if (cnt == (aw+1)'(1)) begin
                st       <= DONE;
                bus.done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer at aw=4: directed capture table, corner sequences and
// randomized captures checked against an arithmetic model of the write schedule.
`timescale 1ns/1ps
module tb_adc_capture_sequencer;
  localparam int NCH = 8, DW = 16, AW = 4, DECW = 10, DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_capture_sequencer_if #(.nch(NCH), .dw(DW), .aw(AW), .decw(DECW)) bus();

  adc_capture_sequencer #(.nch(NCH), .dw(DW), .aw(AW), .decw(DECW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         mode;
    int         decim;
    int         plen;
    logic [7:0] mask;
    int         trig_early;
    int         trig_at;
    int         stop_at;
    int         n_wr;
    int         exp_taddr;
    logic       exp_wrapped;
    logic       exp_done;
    int         exp_waddr;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    bus.arm  = 1'b0;
    bus.trig = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic rand_data();
    bus.adc_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Write k of a capture lands 1+k*d edges after the arm edge at address k mod depth.
  function automatic vec_t model(input int mode, input int decim, input int plen,
                                 input logic [7:0] mask, input int tsel);
    vec_t v;
    int d, armed_from, nt, m;
    d = (decim == 0) ? 1 : decim;
    m = (mode == 3) ? 0 : mode;
    v.mode = mode; v.decim = decim; v.plen = plen; v.mask = mask;
    v.trig_early = 0; v.trig_at = 0; v.stop_at = 0;
    v.exp_taddr = 0; v.exp_wrapped = 1'b0; v.exp_done = 1'b1;
    if (m == 0) begin
      v.n_wr = DEPTH;
      v.trig_early = 1 + tsel % 10;
    end else if (m == 1) begin
      armed_from = (plen == 0) ? 1 : 2 + (plen - 1) * d;
      v.trig_at = armed_from + tsel;
      v.trig_early = (plen > 0) ? 1 : 0;
      nt = (v.trig_at - 1) / d + 1;
      v.n_wr = nt + DEPTH - plen;
      v.exp_taddr = nt % DEPTH;
      v.exp_wrapped = (nt >= DEPTH);
    end else begin
      v.stop_at = 2 + tsel;
      nt = (v.stop_at - 2) / d + 1;
      v.n_wr = nt;
      v.exp_wrapped = (nt >= DEPTH);
      v.exp_done = 1'b0;
    end
    v.exp_waddr = v.n_wr % DEPTH;
    return v;
  endfunction

  task automatic run_capture(input vec_t v, input string tag);
    int d, last, k, seen;
    logic [127:0] cur;
    d = (v.decim == 0) ? 1 : v.decim;
    bus.mode = 2'(v.mode);
    bus.decim = DECW'(v.decim);
    bus.pretrig_len = AW'(v.plen);
    bus.chan_mask = v.mask;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    last = (v.stop_at > 0) ? v.stop_at + 3 : 1 + (v.n_wr - 1) * d + 2;
    seen = 0;
    for (int n = 1; n <= last; n++) begin
      bus.trig = (n == v.trig_at) || (n == v.trig_early);
      bus.stop = (n == v.stop_at);
      cur = {$urandom, $urandom, $urandom, $urandom};
      bus.adc_data = cur;
      tick();
      clear_cmds();
      if (bus.we != 8'h00) seen++;
      k = (n - 1) / d;
      if (((n - 1) % d == 0) && (k < v.n_wr)) begin
        chk({tag, " we"}, 128'(bus.we), 128'(v.mask));
        chk({tag, " waddr"}, 128'(bus.waddr), 128'(k % DEPTH));
        chk({tag, " wdata"}, bus.wdata, cur);
      end else begin
        chk({tag, " we idle"}, 128'(bus.we), 128'(0));
      end
    end
    chk({tag, " writes"}, 128'(seen), 128'(v.n_wr));
    chk({tag, " done"}, 128'(bus.done), 128'(v.exp_done));
    chk({tag, " busy"}, 128'(bus.busy), 128'(0));
    chk({tag, " wrapped"}, 128'(bus.wrapped), 128'(v.exp_wrapped));
    chk({tag, " trig_addr"}, 128'(bus.trig_addr), 128'(v.exp_taddr));
    chk({tag, " waddr end"}, 128'(bus.waddr), 128'(v.exp_waddr));
    chk({tag, " state end"}, 128'(bus.state), 128'(v.exp_done ? 4 : 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, 128'(bus.state), 128'(0));
    chk({tag, " we"}, 128'(bus.we), 128'(0));
    chk({tag, " waddr"}, 128'(bus.waddr), 128'(0));
    chk({tag, " wdata"}, bus.wdata, 128'(0));
    chk({tag, " busy"}, 128'(bus.busy), 128'(0));
    chk({tag, " done"}, 128'(bus.done), 128'(0));
    chk({tag, " wrapped"}, 128'(bus.wrapped), 128'(0));
    chk({tag, " trig_addr"}, 128'(bus.trig_addr), 128'(0));
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    //          mode dec plen mask   early trig stop  nwr taddr wrap done waddr
    vecs[0] = '{0, 1, 0, 8'hFF, 0, 0, 0, 16, 0, 1'b0, 1'b1, 0};
    vecs[1] = '{1, 1, 4, 8'hFF, 0, 10, 0, 22, 10, 1'b0, 1'b1, 6};
    vecs[2] = '{2, 3, 0, 8'h05, 0, 0, 70, 23, 0, 1'b1, 1'b0, 7};
    vecs[3] = '{3, 0, 5, 8'h81, 0, 0, 0, 16, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{1, 2, 0, 8'h3C, 0, 5, 0, 19, 3, 1'b0, 1'b1, 3};
    vecs[5] = '{1, 1, 8, 8'hA5, 3, 12, 0, 20, 12, 1'b0, 1'b1, 4};
    vecs[6] = '{1, 1, 2, 8'h0F, 0, 20, 0, 34, 4, 1'b1, 1'b1, 2};

    rst = 1'b1;
    clear_cmds();
    bus.mode = 2'd0; bus.decim = '0; bus.pretrig_len = '0; bus.chan_mask = '0;
    rand_data();
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_capture(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        bus.stop = 1'b1;
        tick();
        clear_cmds();
        chk("stop in DONE done", 128'(bus.done), 128'(1));
        chk("stop in DONE state", 128'(bus.state), 128'(4));
      end
    end

    // arm together with stop while busy: stop wins, no restart
    bus.mode = 2'd2; bus.decim = DECW'(1); bus.chan_mask = 8'hFF;
    bus.arm = 1'b1; tick(); clear_cmds();
    repeat (5) tick();
    bus.arm = 1'b1; bus.stop = 1'b1; tick(); clear_cmds();
    chk("arm+stop state", 128'(bus.state), 128'(0));
    chk("arm+stop busy", 128'(bus.busy), 128'(0));
    chk("arm+stop done", 128'(bus.done), 128'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arm+stop no write", 128'(bus.we), 128'(0));
    end

    // pretrigger of zero arms directly; arm with trig restarts into PRE
    bus.mode = 2'd1; bus.pretrig_len = '0;
    bus.arm = 1'b1; tick(); clear_cmds();
    chk("plen0 armed", 128'(bus.state), 128'(2));
    repeat (5) tick();
    bus.pretrig_len = AW'(4);
    bus.arm = 1'b1; bus.trig = 1'b1; tick(); clear_cmds();
    chk("arm+trig state", 128'(bus.state), 128'(1));
    chk("arm+trig trig_addr", 128'(bus.trig_addr), 128'(0));
    chk("arm+trig waddr", 128'(bus.waddr), 128'(0));

    // reset mid-capture at waddr 7, overriding arm/trig/stop
    bus.mode = 2'd0; bus.chan_mask = 8'hFF;
    bus.arm = 1'b1; tick(); clear_cmds();
    repeat (8) tick();
    chk("pre-rst waddr", 128'(bus.waddr), 128'(7));
    chk("pre-rst state", 128'(bus.state), 128'(3));
    rand_data();
    rst = 1'b1; bus.arm = 1'b1; bus.trig = 1'b1; bus.stop = 1'b1;
    tick();
    clear_cmds();
    chk_all_zero("mid rst");
    rst = 1'b0;
    tick();
    chk("post rst no write", 128'(bus.we), 128'(0));
    chk("post rst idle", 128'(bus.state), 128'(0));

    for (int i = 0; i < 12; i++) begin
      rv = model(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 8'($urandom_range(1, 255)),
                 int'($urandom_range(0, 40)));
      run_capture(rv, $sformatf("rnd%0d m%0d", i, rv.mode));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
